mmio_uart_tx: RTL and testbench

Memory-mapped UART transmitter that responds to the pipelined CPU's MEM-stage data-bus accesses, which it shares with the data memory. CPU stores to the TXDATA register push bytes into a TX FIFO. A baud-rate FSM serialises the bytes as 8N1 frames on `tx`. CPU loads from STATUS return combinational flags, with the same timing as data-memory reads.

---
 rtl/mmio_uart_tx_if.sv | 19 +
 rtl/mmio_uart_tx.sv | 145 ++++++++++++++
 tb/tb_mmio_uart_tx.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mmio_uart_tx_if.sv
// MEM-stage data-bus view shared by the CPU and the UART transmitter.
// Carries the store strobe, address, store data and combinational read data.
interface mmio_uart_tx_if;
  logic        MemWrite;
  logic [2:0]  funct3;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic [31:0] ReadData;

  modport master (
    output MemWrite, funct3, Address, WriteData,
    input  ReadData
  );

  modport slave (
    input  MemWrite, funct3, Address, WriteData,
    output ReadData
  );
endinterface

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with a TX FIFO.
// TXDATA at BASE_ADDR, STATUS (busy/full/empty/ovf/count) at BASE_ADDR+4.
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR    = 32'h8000_0010,
  parameter int          CLKS_PER_BIT = 868,
  parameter int          FIFO_DEPTH   = 8
) (
  input  logic         clk,
  input  logic         rst,
  mmio_uart_tx_if.slave bus,
  output logic         tx,
  output logic         tx_busy
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e        state_q;
  logic [BW-1:0] baud_q;
  logic [2:0]    bit_idx_q;
  logic [7:0]    shift_q;
  logic          tx_q;
  logic          busy_q;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;

  logic hit, wr_tx, wr_st, pop, push, full, empty, baud_end;
  logic [31:0] status;
  logic unused_bits;

  assign unused_bits = ^{bus.funct3, bus.Address[1:0],
                         bus.WriteData[31:8]};

  always_comb begin
    hit      = bus.Address[31:3] == BASE_ADDR[31:3];
    wr_tx    = bus.MemWrite & hit & ~bus.Address[2];
    wr_st    = bus.MemWrite & hit & bus.Address[2];
    full     = count_q == DEPTH_C;
    empty    = count_q == '0;
    pop      = (state_q == IDLE) & ~empty;
    // A pop in the same cycle frees a slot for a push into a full FIFO
    push     = wr_tx & (~full | pop);
    baud_end = baud_q == BAUD_LAST;

    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    count_d  = count_q;
    if (push & ~pop) count_d = count_q + CW'(1);
    if (pop & ~push) count_d = count_q - CW'(1);

    ovf_d = ovf_q;
    if (wr_tx & ~push)                ovf_d = 1'b1;
    if (wr_st & bus.WriteData[3])     ovf_d = 1'b0;

    status = {24'b0, 4'(count_q), ovf_q, empty, full, busy_q};
    bus.ReadData = (hit & bus.Address[2]) ? status : 32'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.WriteData[7:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      baud_q    <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (pop) begin
            shift_q   <= mem_q[rd_ptr_q];
            bit_idx_q <= '0;
            baud_q    <= '0;
            state_q   <= START;
            tx_q      <= 1'b0;
            busy_q    <= 1'b1;
          end
        end
        START: begin
          if (baud_end) begin
            baud_q  <= '0;
            state_q <= DATA;
            tx_q    <= shift_q[0];
          end else begin
            baud_q <= baud_q + BW'(1);
          end
        end
        DATA: begin
          if (baud_end) begin
            baud_q <= '0;
            if (bit_idx_q == 3'd7) begin
              state_q <= STOP;
              tx_q    <= 1'b1;
            end else begin
              shift_q   <= shift_q >> 1;
              bit_idx_q <= bit_idx_q + 3'd1;
              tx_q      <= shift_q[1];
            end
          end else begin
            baud_q <= baud_q + BW'(1);
          end
        end
        STOP: begin
          if (baud_end) begin
            baud_q  <= '0;
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            baud_q <= baud_q + BW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tx      = tx_q;
  assign tx_busy = busy_q;
endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: directed and random bus traffic, with a
// line-level UART receiver decoding tx frames for comparison.
module tb_mmio_uart_tx;
  localparam logic [31:0] BASE = 32'h8000_0010;
  localparam int C = 4;
  localparam int D = 8;
  localparam int FRAME = 10 * C;

  logic clk = 1'b0;
  logic rst;
  logic tx, tx_busy;
  int   checks = 0;
  int   errors = 0;
  int   cyc_n  = 0;

  logic [7:0] mon_b[$];
  logic       mon_s[$];
  int         mon_t[$];

  mmio_uart_tx_if bus ();

  mmio_uart_tx #(
    .BASE_ADDR(BASE), .CLKS_PER_BIT(C), .FIFO_DEPTH(D)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .tx(tx), .tx_busy(tx_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  // Receiver: finds a start bit, samples every bit at mid-period
  initial begin
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && tx === 1'b0) begin
        automatic int   st = cyc_n;
        automatic bit   ab = 1'b0;
        automatic logic [7:0] b = '0;
        automatic logic sok = 1'b0;
        for (int k = 1; k <= 9 * C + C / 2 && !ab; k++) begin
          @(negedge clk);
          if (rst !== 1'b0) ab = 1'b1;
          else if (k == 9 * C + C / 2) sok = tx;
          else if (k >= C + C / 2 && (k - C - C / 2) % C == 0)
            b[(k - C - C / 2) / C] = tx;
        end
        if (!ab) begin
          mon_b.push_back(b);
          mon_s.push_back(sok);
          mon_t.push_back(st);
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic sw(input logic [31:0] a, input logic [31:0] d,
                    input logic [2:0] f = 3'b010);
    bus.MemWrite  = 1'b1;
    bus.Address   = a;
    bus.WriteData = d;
    bus.funct3    = f;
    cyc();
    bus.MemWrite  = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    bus.MemWrite = 1'b0;
    bus.Address  = a;
    #1;
    d = bus.ReadData;
  endtask

  task automatic clear_mon();
    mon_b.delete();
    mon_s.delete();
    mon_t.delete();
  endtask

  task automatic wait_frames(input int n, input int budget);
    int t = 0;
    while (mon_b.size() < n && t < budget) begin
      cyc();
      t++;
    end
    chk("frame_timeout", mon_b.size(), n);
  endtask

  task automatic chk_frames(input string tag, input logic [7:0] exp[$]);
    for (int i = 0; i < exp.size() && i < mon_b.size(); i++) begin
      chk({tag, "_byte"}, mon_b[i], exp[i]);
      chk({tag, "_stop"}, mon_s[i], 1'b1);
      if (i > 0) chk({tag, "_gap"}, mon_t[i] - mon_t[i-1], FRAME + 1);
    end
  endtask

  initial begin
    logic [31:0] r;
    logic [7:0]  exp_q[$];
    logic [9:0]  bits;
    int          n;
    bit          line_ok;

    bus.MemWrite = 1'b0;
    bus.funct3 = 3'b010;
    bus.Address = '0;
    bus.WriteData = '0;
    rst = 1'b1;
    cyc();
    cyc();
    chk("rst_tx", tx, 1'b1);
    chk("rst_busy", tx_busy, 1'b0);
    rst = 1'b0;
    rd(BASE + 4, r);
    chk("rst_status", r, 32'h4);

    // Single byte, exact line timing
    clear_mon();
    sw(BASE, 32'h0000_00A5);
    bits = {1'b1, 8'hA5, 1'b0};
    bus.Address = BASE + 4;
    for (int i = 0; i < FRAME; i++) begin
      cyc();
      chk("a5_line", tx, bits[i / C]);
      chk("a5_busy", bus.ReadData[0], 1'b1);
    end
    cyc();
    chk("a5_idle_busy", tx_busy, 1'b0);
    rd(BASE + 4, r);
    chk("a5_status_end", r, 32'h4);
    exp_q = {8'hA5};
    chk("a5_nframes", mon_b.size(), 1);
    chk_frames("a5", exp_q);

    // Overflow with back-to-back stores
    clear_mon();
    for (int k = 1; k <= 10; k++) begin
      bus.MemWrite = 1'b1;
      bus.Address = BASE;
      bus.WriteData = 32'(k);
      cyc();
    end
    bus.MemWrite = 1'b0;
    rd(BASE + 4, r);
    chk("ovf_status", r, 32'h8B);
    wait_frames(9, 9 * (FRAME + 1) + 50);
    exp_q = {};
    for (int k = 1; k <= 9; k++) exp_q.push_back(8'(k));
    chk_frames("ovf", exp_q);
    repeat (3 * FRAME) cyc();
    chk("ovf_nframes", mon_b.size(), 9);
    rd(BASE + 4, r);
    chk("ovf_drained", r, 32'h0C);

    // Write-one-to-clear
    sw(BASE + 4, 32'h0);
    rd(BASE + 4, r);
    chk("w1c_zero", r, 32'h0C);
    sw(BASE + 4, 32'h8);
    rd(BASE + 4, r);
    chk("w1c_clear", r, 32'h04);

    // Decode and access size
    clear_mon();
    sw(BASE + 1, 32'h1234_5678, 3'b000);
    sw(BASE + 8, 32'h0000_00AB);
    rd(BASE + 8, r);
    chk("miss_read", r, 32'h0);
    rd(BASE, r);
    chk("txdata_read", r, 32'h0);
    wait_frames(1, 2 * FRAME);
    exp_q = {8'h78};
    chk_frames("sb", exp_q);
    repeat (3 * FRAME) cyc();
    chk("miss_nframes", mon_b.size(), 1);
    rd(BASE + 4, r);
    chk("miss_status", r, 32'h04);

    // Random bursts: from idle, at most D+1 back-to-back bytes fit
    for (int round = 0; round < 4; round++) begin
      clear_mon();
      n = $urandom_range(1, D + 4);
      exp_q = {};
      for (int k = 0; k < n; k++) begin
        logic [7:0] b;
        b = 8'($urandom);
        if (k < D + 1) exp_q.push_back(b);
        bus.MemWrite = 1'b1;
        bus.Address = BASE + 32'($urandom_range(0, 3));
        bus.funct3 = 3'($urandom_range(0, 2));
        bus.WriteData = {24'($urandom), b};
        cyc();
      end
      bus.MemWrite = 1'b0;
      wait_frames(exp_q.size(), exp_q.size() * (FRAME + 1) + 50);
      chk_frames("rnd", exp_q);
      repeat (2 * FRAME) cyc();
      chk("rnd_nframes", mon_b.size(), exp_q.size());
      rd(BASE + 4, r);
      chk("rnd_status", r, (n > D + 1) ? 32'h0C : 32'h04);
      sw(BASE + 4, 32'hFFFF_FFFF);
    end

    // Reset during DATA bit 3 with three bytes still queued
    clear_mon();
    for (int k = 0; k < 4; k++) begin
      bus.MemWrite = 1'b1;
      bus.Address = BASE;
      bus.WriteData = 32'h40 + 32'(k);
      cyc();
    end
    bus.MemWrite = 1'b0;
    repeat (14) cyc();
    chk("mid_busy", tx_busy, 1'b1);
    rst = 1'b1;
    cyc();
    chk("mid_rst_tx", tx, 1'b1);
    chk("mid_rst_busy", tx_busy, 1'b0);
    rst = 1'b0;
    rd(BASE + 4, r);
    chk("mid_rst_status", r, 32'h04);
    line_ok = 1'b1;
    for (int i = 0; i < 4 * FRAME; i++) begin
      cyc();
      if (tx !== 1'b1) line_ok = 1'b0;
    end
    chk("mid_line_idle", line_ok, 1'b1);
    chk("mid_nframes", mon_b.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
